// File: rtl/mem_word_packer_8to32w.sv
// Byte-stream to 32-bit word packer that writes a programmed byte range into a
// 2^AW x 32 buffer, little-endian lanes, padding the final partial word with PAD.
module mem_word_packer_8to32w #(
  parameter int         AW  = 9,
  parameter int         CW  = 12,
  parameter logic [7:0] PAD = 8'hFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] byte_count,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          wren,
  output logic [AW-1:0] wraddress,
  output logic [31:0]   data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0] MAX_COUNT = {1'b1, {(CW-1){1'b0}}};

  state_t        state_reg, state_next;
  logic [AW-1:0] addr_reg;
  logic [CW-1:0] remaining_reg;
  logic [1:0]    lane_reg;
  logic [31:0]   lanes_reg;
  logic          wren_reg;
  logic [AW-1:0] wraddress_reg;
  logic [31:0]   data_reg;

  logic          start_load;
  logic          abort_now;
  logic          accept;
  logic          last_byte;
  logic          emit;
  logic [CW-1:0] count_clamped;
  logic [31:0]   merged;

  assign start_load    = (state_reg == IDLE) && start;
  assign abort_now     = (state_reg != IDLE) && abort;
  assign accept        = (state_reg == LOAD) && in_valid && !abort;
  assign last_byte     = accept && (remaining_reg == CW'(1));
  assign emit          = accept && ((lane_reg == 2'd3) || last_byte);
  assign count_clamped = (byte_count > MAX_COUNT) ? MAX_COUNT : byte_count;

  // Word as it will be written if the byte on in_data is accepted now:
  // current lane takes in_data, higher lanes are forced to PAD.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = (lane_reg == 2'(gi)) ? in_data :
                                 (lane_reg <  2'(gi)) ? PAD     :
                                                        lanes_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (byte_count == '0) ? DONE : LOAD;
      end
      LOAD: begin
        if (abort)          state_next = IDLE;
        else if (last_byte) state_next = LAST;
      end
      LAST: begin
        state_next = abort ? IDLE : DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      lane_reg      <= '0;
    end else if (start_load) begin
      addr_reg      <= base_addr;
      remaining_reg <= count_clamped;
      lane_reg      <= '0;
    end else if (abort_now) begin
      lane_reg      <= '0;
    end else if (accept) begin
      remaining_reg <= remaining_reg - CW'(1);
      lane_reg      <= lane_reg + 2'd1;
      if (emit) addr_reg <= addr_reg + AW'(1);
    end
  end

  // Lanes restart at PAD for every new word so a short tail needs no cleanup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_reg <= '0;
    end else if (start_load || abort_now || emit) begin
      lanes_reg <= {4{PAD}};
    end else if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_reg == 2'(i)) lanes_reg[i*8 +: 8] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren_reg      <= 1'b0;
      wraddress_reg <= '0;
      data_reg      <= '0;
    end else begin
      wren_reg <= emit;
      if (emit) begin
        wraddress_reg <= addr_reg;
        data_reg      <= merged;
      end
    end
  end

  assign in_ready  = (state_reg == LOAD);
  assign busy      = (state_reg == LOAD) || (state_reg == LAST);
  assign done      = (state_reg == DONE);
  assign wren      = wren_reg;
  assign wraddress = wraddress_reg;
  assign data      = data_reg;

endmodule
